// File: rtl/pc_fetch_pkg.sv
// rtl/pc_fetch_pkg.sv - shared FSM states, trap-cause encodings and NOP constant for pc_fetch
package pc_fetch_pkg;

  typedef enum logic [1:0] {
    S_FETCH = 2'b00,
    S_WAIT  = 2'b01,
    S_HOLD  = 2'b10,
    S_TRAP  = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_MISALIGN = 2'b01,
    CAUSE_TIMEOUT  = 2'b10
  } trap_cause_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - single-outstanding instruction fetch with decode handshake, timeout and sticky trap
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_new,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        trap_o,
  output logic [1:0]  trap_cause
);

  localparam int            CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  trap_cause_e      cause_q, cause_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      cnt_q   <= '0;
      cause_q <= CAUSE_NONE;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    unique case (state_q)
      S_FETCH: begin
        // A same-cycle rvalid belongs to nothing we issued, so only the grant counts.
        if (imem_gnt) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          state_d = S_HOLD;
        end else if (cnt_q == CNT_MAX) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (instr_ready) begin
          if (pc_new[1:0] == 2'b00) begin
            pc_d    = pc_new;
            state_d = S_FETCH;
          end else begin
            state_d = S_TRAP;
            cause_d = CAUSE_MISALIGN;
          end
        end
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_comb begin
    imem_req    = (state_q == S_FETCH) && !rst;
    instr_valid = (state_q == S_HOLD);
    trap_o      = (state_q == S_TRAP);
  end

  assign imem_addr  = pc_q;
  assign pc_o       = pc_q;
  assign instr_o    = instr_q;
  assign trap_cause = cause_q;

endmodule

// File: tb/tb_pc_fetch.sv
// tb/tb_pc_fetch.sv - scoreboard bench for pc_fetch with randomized memory latency and retire targets
module tb_pc_fetch;
  import pc_fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          TMO    = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_new;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        instr_valid;
  logic        instr_ready;
  logic        trap_o;
  logic [1:0]  trap_cause;

  pc_fetch #(.RESET_PC(RST_PC), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .pc_new(pc_new),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_o(instr_o), .pc_o(pc_o), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .trap_o(trap_o), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  bit          presented = 1'b0;
  int          total = 0;
  int          bad = 0;
  logic [31:0] model_pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  // Monitor: each newly presented instruction pops one expectation and must stay stable while held.
  always @(negedge clk) begin
    if (instr_valid === 1'b1) begin
      if (!presented) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_underflow actual=pc %h required=no instruction", pc_o);
        end else begin
          cur       = sb.pop_front();
          presented = 1'b1;
        end
      end
      if (presented) begin
        check("mon_instr", instr_o, cur.instr);
        check("mon_pc", pc_o, cur.pc);
      end
    end else begin
      presented = 1'b0;
    end
  end

  task automatic fetch_one(input int gd, input int rd, input logic [31:0] data, input bit dup);
    for (int i = 0; i <= gd; i++) begin
      chkb("fetch_req", imem_req, 1'b1);
      check("fetch_addr", imem_addr, model_pc);
      imem_gnt    = (i == gd);
      imem_rvalid = (i == gd) ? dup : 1'($urandom_range(0, 1));
      imem_rdata  = $urandom;
      @(negedge clk);
    end
    imem_gnt = 1'b0;
    for (int i = 0; i <= rd; i++) begin
      chkb("wait_req", imem_req, 1'b0);
      chkb("wait_valid", instr_valid, 1'b0);
      imem_rvalid = (i == rd);
      imem_rdata  = (i == rd) ? data : $urandom;
      if (i == rd) sb.push_back('{pc: model_pc, instr: data});
      @(negedge clk);
    end
    imem_rvalid = 1'b0;
    chkb("valid_after_rvalid", instr_valid, 1'b1);
  endtask

  task automatic retire(input int w, input logic [31:0] pcn);
    for (int i = 0; i < w; i++) begin
      chkb("hold_valid", instr_valid, 1'b1);
      chkb("hold_no_req", imem_req, 1'b0);
      instr_ready = 1'b0;
      pc_new      = $urandom | 32'h1;
      @(negedge clk);
    end
    instr_ready = 1'b1;
    pc_new      = pcn;
    @(negedge clk);
    instr_ready = 1'b0;
    pc_new      = $urandom;
    if (pcn[1:0] == 2'b00) model_pc = pcn;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chkb("rst_req", imem_req, 1'b0);
    chkb("rst_valid", instr_valid, 1'b0);
    chkb("rst_trap", trap_o, 1'b0);
    check("rst_cause", {30'b0, trap_cause}, 32'h0);
    check("rst_pc", pc_o, RST_PC);
    check("rst_instr", instr_o, NOP_INSTR);
    rst      = 1'b0;
    model_pc = RST_PC;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; pc_new = '0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    imem_rdata = '0; instr_ready = 1'b0; model_pc = RST_PC;
    do_reset();

    // First fetch, retire after stall, then delayed grant.
    fetch_one(0, 0, 32'h0050_0093, 1'b0);
    retire(5, 32'h0000_0004);
    fetch_one(3, 0, 32'h1234_5678, 1'b0);
    retire(0, {$urandom} & 32'hFFFF_FFFC);

    for (int n = 0; n < 40; n++) begin
      fetch_one($urandom_range(0, 4), $urandom_range(0, TMO - 1), $urandom, 1'($urandom_range(0, 1)));
      retire($urandom_range(0, 3), {$urandom} & 32'hFFFF_FFFC);
    end

    // Misaligned retire target.
    fetch_one(1, 1, $urandom, 1'b0);
    retire(0, 32'h0000_0102);
    chkb("mis_trap", trap_o, 1'b1);
    check("mis_cause", {30'b0, trap_cause}, 32'h1);
    check("mis_pc_kept", pc_o, model_pc);
    for (int i = 0; i < 5; i++) begin
      imem_gnt = 1'($urandom_range(0, 1)); imem_rvalid = 1'($urandom_range(0, 1));
      instr_ready = 1'($urandom_range(0, 1)); pc_new = $urandom & 32'hFFFF_FFFC;
      @(negedge clk);
      chkb("trap_no_req", imem_req, 1'b0);
      chkb("trap_no_valid", instr_valid, 1'b0);
      chkb("trap_sticky", trap_o, 1'b1);
      check("trap_cause_sticky", {30'b0, trap_cause}, 32'h1);
    end
    imem_gnt = 1'b0; imem_rvalid = 1'b0; instr_ready = 1'b0;

    // Timeout: trap lands exactly TMO cycles after entering the wait state.
    do_reset();
    chkb("to_req", imem_req, 1'b1);
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    for (int k = 0; k <= TMO; k++) begin
      chkb($sformatf("to_trap_c%0d", k), trap_o, k == TMO);
      if (k == TMO) check("to_cause", {30'b0, trap_cause}, 32'h2);
      else @(negedge clk);
    end

    // Response on the last allowed wait cycle still completes normally.
    do_reset();
    fetch_one(0, TMO - 1, 32'hCAFE_0001, 1'b0);
    chkb("late_ok_no_trap", trap_o, 1'b0);
    retire(0, 32'h0000_0040);

    // Reset during an outstanding fetch at 0x40.
    check("mid_addr", imem_addr, 32'h0000_0040);
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chkb("mid_rst_req", imem_req, 1'b0);
    chkb("mid_rst_valid", instr_valid, 1'b0);
    check("mid_rst_pc", pc_o, RST_PC);
    check("mid_rst_instr", instr_o, NOP_INSTR);
    @(negedge clk);
    rst = 1'b0; model_pc = RST_PC;
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_rvalid = 1'b0;
    chkb("mid_late_rvalid_ignored", instr_valid, 1'b0);
    fetch_one(1, 2, 32'h0000_0513, 1'b0);
    retire(1, 32'h0000_0008);
    @(negedge clk);

    check("sb_drained", sb.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first instruction fetched after reset.
REQ-002 Parameter TIMEOUT, default 16, maximum cycles allowed in S_WAIT before a bus error.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 pc_new  in  32  next PC from the branch/next-PC stage; sampled only at instruction retire.
REQ-006 imem_req  out  1  instruction-memory request.
REQ-007 imem_addr  out  32  fetch address; equals pc_o.
REQ-008 imem_gnt  in  1  memory accepted the request this cycle.
REQ-009 imem_rvalid  in  1  imem_rdata is valid this cycle.
REQ-010 imem_rdata  in  32  fetched instruction word.
REQ-011 instr_o  out  32  latched instruction presented to decode.
REQ-012 pc_o  out  32  PC of instr_o and of the current fetch.
REQ-013 instr_valid  out  1  instr_o/pc_o hold a fetched instruction.
REQ-014 instr_ready  in  1  downstream retires the instruction this cycle.
REQ-015 trap_o  out  1  sticky fault indicator.
REQ-016 trap_cause  out  2  00 none, 01 misaligned pc_new, 10 fetch timeout.

Function
REQ-017 The FSM SHALL have states S_FETCH, S_WAIT, S_HOLD and S_TRAP.
REQ-018 S_FETCH: imem_req=1, imem_addr=pc_o held stable until imem_gnt=1 -> S_WAIT; imem_rvalid in S_FETCH is ignored.
REQ-019 S_WAIT: imem_req=0; on imem_rvalid=1, instr_o <= imem_rdata -> S_HOLD.
REQ-020 S_WAIT: a counter increments each cycle without imem_rvalid; on reaching TIMEOUT-1 with no rvalid -> S_TRAP, trap_cause=10.
REQ-021 The timeout counter SHALL clear on every entry to S_WAIT; width clog2(TIMEOUT), no wrap.
REQ-022 S_HOLD: instr_valid=1; instr_o and pc_o stable until instr_ready=1.
REQ-023 S_HOLD with instr_ready=1 and pc_new[1:0]==00: pc_o <= pc_new -> S_FETCH (next request issued the cycle after retire).
REQ-024 S_HOLD with instr_ready=1 and pc_new[1:0]!=00: pc_o unchanged -> S_TRAP, trap_cause=01.
REQ-025 S_TRAP: imem_req=0, instr_valid=0, trap_o=1; absorbing until reset; all inputs ignored.
REQ-026 instr_valid SHALL be 1 only in S_HOLD; instr_ready outside S_HOLD is ignored.
REQ-027 Minimum fetch-to-valid latency: request cycle with gnt=1, rvalid next cycle, instr_valid the cycle after (3 cycles from S_FETCH entry).
REQ-028 imem_gnt and imem_rvalid in the same S_FETCH cycle: the grant is taken, the rvalid is dropped, and the block waits in S_WAIT.
REQ-029 pc_new is added/compared at full 32 bits; no PC increment is performed inside this block.

Reset
REQ-030 While rst=1: state=S_FETCH, pc_o=RESET_PC, instr_o=32'h0000_0013 (NOP), instr_valid=0, trap_o=0, trap_cause=00, counter=0.
REQ-031 Reset asserted mid-transaction SHALL abandon the outstanding fetch; the first request after release uses RESET_PC.
REQ-032 imem_req SHALL be 0 while rst=1 and SHALL assert in the first cycle after release.

Structure
REQ-033 State enum, trap-cause encodings and the NOP constant SHALL live in the shared definitions package.
REQ-034 No sub-module; FSM, PC register, instruction latch and timeout counter SHALL be in one module.

Verification
REQ-035 Reset release, gnt=1 immediately, rvalid next cycle with 32'h00500093 -> imem_addr=0, instr_valid=1 with instr_o=32'h00500093, pc_o=0.
REQ-036 Retire with pc_new=32'h0000_0004, gnt delayed 3 cycles -> imem_addr=4 held stable for 4 request cycles, imem_req drops after gnt.
REQ-037 Retire with pc_new=32'h0000_0102 -> trap_o=1, trap_cause=01, pc_o unchanged, imem_req=0 thereafter.
REQ-038 TIMEOUT=16, no rvalid after grant -> trap_cause=10 exactly 16 cycles after S_WAIT entry; rvalid on cycle 15 -> normal S_HOLD.
REQ-039 instr_ready=0 for 5 cycles in S_HOLD -> instr_o/pc_o unchanged, no new request; instr_ready=1 -> request for pc_new next cycle.
REQ-040 rst pulsed while in S_WAIT at pc=32'h40 -> outputs at reset values immediately; next request at RESET_PC; late rvalid ignored.
